// File: rtl/mem_copy_dma_if.sv
// Request/status and data-memory port bundle for the word-copy DMA engine.
// The slave modport is the DMA's view; master is the requester plus memory side.
interface mem_copy_dma_if #(
  parameter int AW    = 32,
  parameter int LEN_W = 11
);
  logic             start;
  logic [AW-1:0]    src_addr;
  logic [AW-1:0]    dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             error;
  logic             mem_ren;
  logic             mem_wen;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;

  modport slave (
    input  start, src_addr, dst_addr, len, mem_dout,
    output busy, done, error, mem_ren, mem_wen, mem_addr, mem_din
  );

  modport master (
    output start, src_addr, dst_addr, len, mem_dout,
    input  busy, done, error, mem_ren, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-copy DMA: alternates one read and one write per cycle from src to dst.
// Requests that would touch memory outside the implemented range are rejected up front.
module mem_copy_dma #(
  parameter int AW     = 32,
  parameter int LEN_W  = 11,
  parameter int MEM_AW = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_copy_dma_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_data;
  logic             r_err;

  logic [AW:0]      w_src_end;
  logic [AW:0]      w_dst_end;
  logic [AW:0]      w_lim;
  logic             w_hi_bad;
  logic             w_reject;
  logic             w_zero;

  // End addresses are one bit wider than AW so that an overflowing range is still caught.
  assign w_src_end = {1'b0, bus.src_addr} + {{(AW+1-LEN_W){1'b0}}, bus.len} - (AW+1)'(1);
  assign w_dst_end = {1'b0, bus.dst_addr} + {{(AW+1-LEN_W){1'b0}}, bus.len} - (AW+1)'(1);
  assign w_lim     = {{(AW+1-MEM_AW){1'b0}}, {MEM_AW{1'b1}}};
  assign w_hi_bad  = (|bus.src_addr[AW-1:MEM_AW]) | (|bus.dst_addr[AW-1:MEM_AW]);
  assign w_reject  = w_hi_bad | (w_src_end > w_lim) | (w_dst_end > w_lim);
  assign w_zero    = (bus.len == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    bus.error    = 1'b0;
    bus.mem_ren  = 1'b0;
    bus.mem_wen  = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_next = (w_reject || w_zero) ? S_DONE : S_READ;
      end
      S_READ: begin
        bus.mem_ren  = 1'b1;
        bus.mem_addr = r_src;
        w_next       = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_wen  = 1'b1;
        bus.mem_addr = r_dst;
        bus.mem_din  = r_data;
        w_next       = (r_cnt == LEN_W'(1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        bus.error = r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_err <= w_reject;
          if (!w_reject && !w_zero) begin
            r_src <= bus.src_addr;
            r_dst <= bus.dst_addr;
            r_cnt <= bus.len;
          end
        end
        S_READ:  r_data <= bus.mem_dout;
        S_WRITE: begin
          r_src <= r_src + AW'(1);
          r_dst <= r_dst + AW'(1);
          r_cnt <= r_cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: negedge-commit memory model, golden memory and write scoreboard.
module tb_mem_copy_dma;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_copy_dma_if mif();
  mem_copy_dma dut (.i_clk(clk), .i_rst(rst), .bus(mif));

  logic [31:0] mem [1024];
  logic [31:0] gm  [1024];

  assign mif.mem_dout = mif.mem_ren ? mem[mif.mem_addr[9:0]] : 32'h0;
  always @(negedge clk) if (mif.mem_wen) mem[mif.mem_addr[9:0]] = mif.mem_din;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a request at the current negedge and checks every cycle through the one after done.
  task automatic run_xfer(input int src, input int dst, input int len, input bit exp_err,
                          input bit poke);
    int n;
    wr_t w;
    n = (exp_err || len == 0) ? 1 : 2*len + 1;
    if (!exp_err)
      for (int k = 0; k < len; k++) begin
        gm[dst+k] = gm[src+k];
        sb.push_back('{dst+k, gm[src+k]});
      end
    mif.src_addr = src;
    mif.dst_addr = dst;
    mif.len      = 11'(len);
    mif.start    = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    if (poke) begin
      mif.src_addr = 32'h3FF;
      mif.dst_addr = 32'h3FF;
      mif.len      = 11'd5;
    end
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      check("excl", mif.mem_ren & mif.mem_wen, 0);
      if (c < n) begin
        check("busy", mif.busy, 1);
        check("done_early", mif.done, 0);
        if (c % 2 == 1) begin
          check("ren", {mif.mem_ren, mif.mem_wen}, 2'b10);
          check("raddr", mif.mem_addr, src + (c-1)/2);
        end else begin
          check("wen", {mif.mem_ren, mif.mem_wen}, 2'b01);
          if (sb.size() == 0) check("sb_empty", 1, 0);
          else begin
            w = sb.pop_front();
            check("waddr", mif.mem_addr, w.addr);
            check("wdata", mif.mem_din, w.data);
          end
        end
      end else if (c == n) begin
        check("done", mif.done, 1);
        check("error", mif.error, exp_err);
        check("busy_d", mif.busy, 1);
        check("idle_bus", {mif.mem_ren, mif.mem_wen}, 2'b00);
      end else begin
        check("busy_end", mif.busy, 0);
        check("done_end", mif.done, 0);
      end
      mif.start = (poke && c <= n && (c == 3 || c == n)) ? 1'b1 : 1'b0;
    end
    check("sb_left", sb.size(), 0);
    for (int k = 0; k < len && !exp_err; k++) check("mem", mem[dst+k], gm[dst+k]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hC0DE0000 | 32'(i);
      gm[i]  = mem[i];
    end
    rst = 1'b1;
    mif.start = 1'b0;
    mif.src_addr = '0;
    mif.dst_addr = '0;
    mif.len = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", {mif.busy, mif.done, mif.error, mif.mem_ren, mif.mem_wen}, 0);
    check("rst_addr", mif.mem_addr, 0);
    check("rst_din", mif.mem_din, 0);
    rst = 1'b0;
    @(negedge clk);

    run_xfer(32'h010, 32'h100, 4, 0, 0);
    check("t1_w0", mem[32'h100], 32'hC0DE0010);
    check("t1_w3", mem[32'h103], 32'hC0DE0013);
    run_xfer(32'h020, 32'h200, 0, 0, 0);
    run_xfer(32'h3FE, 32'h300, 4, 1, 0);
    check("t3_nowrite", mem[32'h300], 32'hC0DE0300);
    run_xfer(32'h010, 32'h400, 4, 1, 0);
    run_xfer(32'h040, 32'h140, 3, 0, 1);
    run_xfer(32'h050, 32'h150, 2, 0, 0);
    run_xfer(32'h000, 32'h001, 3, 0, 0);
    check("ovl_1", mem[1], 32'hC0DE0000);
    check("ovl_3", mem[3], 32'hC0DE0000);

    // Reset in the WRITE cycle of word 2 (cycle 6), before its negedge commit.
    mif.src_addr = 32'h060;
    mif.dst_addr = 32'h160;
    mif.len      = 11'd8;
    mif.start    = 1'b1;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rst_pre_wen", mif.mem_wen, 1);
    check("rst_pre_addr", mif.mem_addr, 32'h162);
    rst = 1'b1;
    #1;
    check("rst_mid", {mif.busy, mif.mem_ren, mif.mem_wen, mif.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_nodone", {mif.done, mif.busy}, 0);
    end
    check("rst_w0", mem[32'h160], 32'hC0DE0060);
    check("rst_w1", mem[32'h161], 32'hC0DE0061);
    check("rst_w2", mem[32'h162], 32'hC0DE0162);
    gm[32'h160] = gm[32'h060];
    gm[32'h161] = gm[32'h061];

    run_xfer(32'h070, 32'h170, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
